// File: rtl/trigger_pkg.sv
// Shared types and constants for the trigger capture block.
// FSM state type, default parameters, saturation helper.
package trigger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_HOLD
  } state_e;

  localparam int unsigned FILTER_LEN_DEF = 4;
  localparam int unsigned WIDTH_BITS_DEF = 16;
  localparam int unsigned COUNT_BITS_DEF = 8;

  // All-ones value of a counter that is bits wide (bits <= 32).
  // For bits == 32 the shift yields 0 and the subtraction wraps.
  function automatic logic [31:0] sat_max(
    input int unsigned bits
  );
    sat_max = (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/trigger_sync_filter.sv
// Synchronizer, glitch filter and edge detect for the trigger line.
// In: Clk, Reset, Input_In. Out: flt (level), rise, fall (1-cycle).
module trigger_sync_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Input_In,
  output logic flt,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);

  logic       sync1_q;
  logic       sync2_q;
  logic       flt_q;
  logic       flt_d;
  logic       flt_dly_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // The counter only runs while the synchronized level disagrees
  // with the filtered one; any agreement restarts the qualification.
  always_comb begin
    cnt_d = '0;
    flt_d = flt_q;
    if (sync2_q != flt_q) begin
      if (cnt_q == CNT_LAST) begin
        flt_d = ~flt_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      flt_q     <= 1'b0;
      flt_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= Input_In;
      sync2_q   <= sync1_q;
      flt_q     <= flt_d;
      flt_dly_q <= flt_q;
      cnt_q     <= cnt_d;
    end
  end

  assign flt  = flt_q;
  assign rise = flt_q & ~flt_dly_q;
  assign fall = ~flt_q & flt_dly_q;

endmodule

// File: rtl/trigger_capture.sv
// Trigger receive: filtered edge pulse, pulse-width capture, events.
// In: Clk, Reset, Input_In, Width_Ack. Out: Trig_Pulse, Level_Out,
// Width_Out, Width_Valid, Overrun, Event_Count.
module trigger_capture
  import trigger_pkg::*;
#(
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEF,
  parameter int unsigned WIDTH_BITS = WIDTH_BITS_DEF,
  parameter int unsigned COUNT_BITS = COUNT_BITS_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Input_In,
  output logic                  Trig_Pulse,
  output logic                  Level_Out,
  output logic [WIDTH_BITS-1:0] Width_Out,
  output logic                  Width_Valid,
  input  logic                  Width_Ack,
  output logic                  Overrun,
  output logic [COUNT_BITS-1:0] Event_Count
);

  localparam logic [WIDTH_BITS-1:0] W_MAX =
    WIDTH_BITS'(sat_max(WIDTH_BITS));
  localparam logic [WIDTH_BITS-1:0] W_ONE = WIDTH_BITS'(1);
  localparam logic [COUNT_BITS-1:0] E_ONE = COUNT_BITS'(1);

  logic flt;
  logic rise;
  logic fall;

  state_e                state_q;
  state_e                state_d;
  logic [WIDTH_BITS-1:0] wcnt_q;
  logic [WIDTH_BITS-1:0] wcnt_d;
  logic [WIDTH_BITS-1:0] wout_q;
  logic [WIDTH_BITS-1:0] wout_d;
  logic                  wvld_q;
  logic                  wvld_d;
  logic                  ovr_q;
  logic                  ovr_d;
  logic [COUNT_BITS-1:0] evt_q;
  logic [COUNT_BITS-1:0] evt_d;

  trigger_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sf (
    .Clk     (Clk),
    .Reset   (Reset),
    .Input_In(Input_In),
    .flt     (flt),
    .rise    (rise),
    .fall    (fall)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    wout_d  = wout_q;
    wvld_d  = wvld_q;
    ovr_d   = ovr_q;
    evt_d   = rise ? evt_q + E_ONE : evt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_MEASURE;
          wcnt_d  = W_ONE;
        end
      end
      ST_MEASURE: begin
        if (fall) begin
          state_d = ST_HOLD;
          wout_d  = wcnt_q;
          wvld_d  = 1'b1;
        end else if (flt && (wcnt_q != W_MAX)) begin
          wcnt_d = wcnt_q + W_ONE;
        end
      end
      ST_HOLD: begin
        // An ack in the same cycle as a new edge frees the slot,
        // so that edge starts a fresh measurement instead.
        if (Width_Ack) begin
          wvld_d = 1'b0;
          if (rise) begin
            state_d = ST_MEASURE;
            wcnt_d  = W_ONE;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (rise) begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      wout_q  <= '0;
      wvld_q  <= 1'b0;
      ovr_q   <= 1'b0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      wout_q  <= wout_d;
      wvld_q  <= wvld_d;
      ovr_q   <= ovr_d;
      evt_q   <= evt_d;
    end
  end

  assign Trig_Pulse  = rise;
  assign Level_Out   = flt;
  assign Width_Out   = wout_q;
  assign Width_Valid = wvld_q;
  assign Overrun     = ovr_q;
  assign Event_Count = evt_q;

endmodule
